imem_loader: RTL and testbench

Boot-time program loader that writes the instruction memory the fetch stage reads. It accepts a byte stream over a valid/ready handshake, parses a 16-bit little-endian word-count header, and packs the following bytes little-endian into 32-bit words. It writes each word into the instruction memory write port at consecutive word addresses from 0. It holds the CPU in reset (`cpu_hold`) until the image is fully written.

---
 rtl/loader_pkg.sv | 28 ++
 rtl/imem_loader_word_packer.sv | 44 ++++
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  // Loader sequencing: two header bytes, payload words, one write-finish cycle.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WFIN   = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } loader_state_t;

  // Header word-count width.
  localparam int LEN_W = 16;

  // Byte lanes within a 32-bit instruction word (little-endian).
  localparam int         LANE_W    = 8;
  localparam int         NUM_LANES = 4;
  localparam logic [1:0] LAST_LANE = 2'd3;

  // States in which the loader is willing to accept a byte.
  function automatic logic takes_bytes(input loader_state_t s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA);
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; flags the fourth byte.
module word_packer
  import loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         byte_en,
  input  logic [LANE_W-1:0]            byte_in,
  output logic [NUM_LANES*LANE_W-1:0]  word_out,
  output logic                         word_full
);

  logic [1:0]                    byte_idx_q, byte_idx_d;
  logic [NUM_LANES*LANE_W-1:0]   lane_q;

  // Merge the incoming byte into its lane so the completed word is visible
  // in the same cycle as its fourth byte.
  always_comb begin
    word_out = lane_q;
    if (byte_en) begin
      case (byte_idx_q)
        2'd0:    word_out[7:0]   = byte_in;
        2'd1:    word_out[15:8]  = byte_in;
        2'd2:    word_out[23:16] = byte_in;
        default: word_out[31:24] = byte_in;
      endcase
    end
    byte_idx_d = byte_en ? byte_idx_q + 2'd1 : byte_idx_q;
    word_full  = byte_en && (byte_idx_q == LAST_LANE);
  end

  // Lane register and byte index; clear drops any partial word.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_idx_q <= 2'd0;
      lane_q     <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      lane_q     <= word_out;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a 16-bit word-count header, streams words into the
// instruction memory from address 0 and holds the CPU until the image is in.
//
// Handshake: a byte moves on every rising edge where rx_valid && rx_ready;
// rx_ready depends on loader state only and never on rx_valid.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output loader_state_t     dbg_state
);

  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH_WORDS);

  loader_state_t     state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0]  len_full;
  logic              rx_ready_q, imem_we_q, cpu_hold_q, busy_q, done_q, error_q;
  logic [ADDR_W-1:0] imem_waddr_q;
  logic [31:0]       imem_wdata_q;

  logic        xfer;
  logic        pk_clear, pk_byte_en, pk_full;
  logic [31:0] pk_word;
  logic        last_word;

  assign xfer       = rx_valid && rx_ready_q;
  assign len_full   = {rx_data, len_q[7:0]};
  assign last_word  = (word_cnt_q + 16'd1) == len_q;
  assign pk_byte_en = xfer && (state_q == S_DATA);

  word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .byte_en   (pk_byte_en),
    .byte_in   (rx_data),
    .word_out  (pk_word),
    .word_full (pk_full)
  );

  // Next-state, header capture and word counting.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    pk_clear   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d      = len_full;
          word_cnt_d = '0;
          pk_clear   = 1'b1;
          if (len_full == '0)            state_d = S_DONE;
          else if (len_full > DEPTH_LEN) state_d = S_ERROR;
          else                           state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (pk_full) begin
          word_cnt_d = word_cnt_q + 16'd1;
          if (last_word) state_d = S_WFIN;
        end
      end
      S_WFIN:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State plus all registered outputs, decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      rx_ready_q <= takes_bytes(state_d);
      busy_q     <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                    (state_d == S_DATA)   || (state_d == S_WFIN);
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERROR);
      cpu_hold_q <= (state_d != S_DONE);
      imem_we_q  <= pk_full;
      if (pk_full) begin
        imem_waddr_q <= word_cnt_q[ADDR_W-1:0];
        imem_wdata_q <= pk_word;
      end
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected memory writes.
module tb_imem_loader;
  import loader_pkg::*;

  localparam int ADDR_W = 10;
  localparam int SB_W   = ADDR_W + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready, imem_we, cpu_hold, busy, done, error;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  loader_state_t     dbg_state;

  imem_loader #(.DEPTH_WORDS(1024), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [SB_W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_writes = 0;
  int last_we_cyc = 0;
  bit have_last = 0;
  bit gap_chk = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (imem_we) begin
      if (gap_chk && have_last) check_eq("we_gap", 64'(cyc - last_we_cyc), 64'd4);
      last_we_cyc = cyc;
      have_last   = 1;
      n_writes++;
      last_addr = imem_waddr;
      if (exp_q.size() == 0) begin
        check_eq("unexp_we", {63'd0, imem_we}, 64'd0);
      end else begin
        logic [SB_W-1:0] e;
        e = exp_q.pop_front();
        check_eq("wr", 64'({imem_waddr, imem_wdata}), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte until it is taken; optional random idle cycles first.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit taken;
    int tmo;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    tmo = 0;
    forever begin
      @(negedge clk);
      taken = rx_ready;
      tick();
      if (taken) break;
      tmo++;
      if (tmo > 50) begin
        check_eq("byte_timeout", 64'(tmo), 64'd0);
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] len);
    send_byte(len[7:0], 1'b0);
    send_byte(len[15:8], 1'b0);
  endtask

  // Push the expected write, then stream its four bytes.
  task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] w, input bit gaps);
    exp_q.push_back({addr, w});
    send_byte(w[7:0], gaps);
    send_byte(w[15:8], gaps);
    send_byte(w[23:16], gaps);
    send_byte(w[31:24], gaps);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      tick();
    end
    check_eq("done_wait", {63'd0, done}, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;

    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset values.
    check_eq("rst_state", 64'(dbg_state), 64'(S_IDLE));
    check_eq("rst_hold", {63'd0, cpu_hold}, 64'd1);
    check_eq("rst_ready", {63'd0, rx_ready}, 64'd0);
    check_eq("rst_we", {63'd0, imem_we}, 64'd0);
    check_eq("rst_addr", 64'(imem_waddr), 64'd0);
    check_eq("rst_data", 64'(imem_wdata), 64'd0);
    check_eq("rst_flags", {61'd0, busy, done, error}, 64'd0);

    // Basic two-word load; start arrives with a byte already offered.
    rx_valid = 1'b1;
    rx_data  = 8'h02;
    check_eq("idle_ready", {63'd0, rx_ready}, 64'd0);
    pulse_start();
    check_eq("lenlo_state", 64'(dbg_state), 64'(S_LEN_LO));
    check_eq("lenlo_busy", {62'd0, busy, cpu_hold}, 64'd3);
    send_len(16'd2);
    check_eq("data_state", 64'(dbg_state), 64'(S_DATA));
    send_word(10'd0, 32'h0000_0013, 1'b0);
    send_word(10'd1, 32'h0010_0093, 1'b0);
    // Cycle N+1: final write, still holding the CPU.
    check_eq("wfin_state", 64'(dbg_state), 64'(S_WFIN));
    check_eq("wfin_we", {63'd0, imem_we}, 64'd1);
    check_eq("wfin_ready", {63'd0, rx_ready}, 64'd0);
    check_eq("wfin_hold", {62'd0, cpu_hold, done}, 64'd2);
    tick();
    // Cycle N+2: released.
    check_eq("rel_hold_done", {62'd0, cpu_hold, done}, 64'd1);
    check_eq("rel_busy", {63'd0, busy}, 64'd0);
    check_eq("sb_basic", 64'(exp_q.size()), 64'd0);

    // Empty image.
    pulse_start();
    check_eq("restart_hold", {62'd0, cpu_hold, done}, 64'd2);
    send_len(16'd0);
    check_eq("zero_state", 64'(dbg_state), 64'(S_DONE));
    check_eq("zero_done", {62'd0, cpu_hold, done}, 64'd1);

    // Oversized header.
    pulse_start();
    send_len(16'd1025);
    check_eq("err_state", 64'(dbg_state), 64'(S_ERROR));
    check_eq("err_flags", {60'd0, error, cpu_hold, rx_ready, busy}, 64'hC);
    pulse_start();
    check_eq("err_clear", {63'd0, error}, 64'd0);
    check_eq("err_restart", 64'(dbg_state), 64'(S_LEN_LO));

    // Full-depth image, continuous stream, strobes every 4 cycles.
    send_len(16'd1024);
    have_last = 0;
    gap_chk   = 1;
    for (int i = 0; i < 1024; i++) send_word(ADDR_W'(i), $urandom, 1'b0);
    gap_chk = 0;
    wait_done(10);
    check_eq("full_last_addr", 64'(last_addr), 64'd1023);
    check_eq("sb_full", 64'(exp_q.size()), 64'd0);

    // Bursty valid, three words.
    n_writes = 0;
    pulse_start();
    send_len(16'd3);
    for (int i = 0; i < 3; i++) send_word(ADDR_W'(i), $urandom, 1'b1);
    wait_done(10);
    check_eq("gap_nwrites", 64'(n_writes), 64'd3);

    // Reset mid-load after six data bytes.
    n_writes = 0;
    pulse_start();
    send_len(16'd4);
    w0 = $urandom;
    send_word(10'd0, w0, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    reset = 1'b1;
    tick();
    check_eq("mid_rst_state", 64'(dbg_state), 64'(S_IDLE));
    check_eq("mid_rst_hold", {62'd0, cpu_hold, rx_ready}, 64'd2);
    reset = 1'b0;
    repeat (6) tick();
    check_eq("mid_rst_nwrites", 64'(n_writes), 64'd1);
    pulse_start();
    send_len(16'd1);
    send_word(10'd0, 32'hCAFE_F00D, 1'b0);
    wait_done(10);
    check_eq("reload_addr", 64'(last_addr), 64'd0);
    check_eq("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
